arith_result_buffer: RTL and testbench
======================================

ARITH_RESULT_BUFFER -- requirements
Module: arith_result_buffer

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the FIFO entry count; legal values are 2, 4 and 8.
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have a port clr, input, 1 bit: synchronous clear of the accumulator, acc_ovf and count.
REQ-005 The block SHALL have a port in_valid, input, 1 bit: the upstream arithmetic result is valid.
REQ-006 The block SHALL have a port in_ready, output, 1 bit: the buffer can accept a result.
REQ-007 The block SHALL have ports in_w, in_x and in_z, inputs, 11 bits each, and in_y, input, 18 bits: the arithmetic results w, x, y and z.
REQ-008 The block SHALL have a port out_valid, output, 1 bit: the head entry is valid.
REQ-009 The block SHALL have a port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-010 The block SHALL have ports out_w, out_x and out_z, outputs, 11 bits each, and out_y, output, 18 bits: the head entry fields.
REQ-011 The block SHALL have a port acc, output, 24 bits: the running sum of accepted in_y values.
REQ-012 The block SHALL have a port acc_ovf, output, 1 bit: sticky accumulator overflow flag.
REQ-013 The block SHALL have a port count, output, 16 bits: the number of accepted results.
REQ-014 The block SHALL have ports full and empty, outputs, 1 bit each: the FIFO status flags.

Function
REQ-015 The block SHALL treat a push as in_valid && in_ready, and a pop as out_valid && out_ready.
REQ-016 The block SHALL keep level state with three states: EMPTY (level 0), PARTIAL (level 1..DEPTH-1) and FULL (level DEPTH).
REQ-017 The block SHALL derive in_ready = !full, out_valid = !empty, full = (state == FULL) and empty = (state == EMPTY), all from registers only, with no combinational path from the in_* or out_ready ports.
REQ-018 The block SHALL operate first-word-fall-through: out_* show the head entry combinationally from storage, and a push into EMPTY makes out_valid high on the next cycle (latency 1).
REQ-019 The block SHALL handle a simultaneous push and pop in PARTIAL by keeping the level unchanged and advancing both pointers.
REQ-020 The block SHALL never push in FULL, because in_ready is low, and SHALL perform no pop in EMPTY; there is no bypass path.
REQ-021 The block SHALL wrap the read and write pointers modulo DEPTH.
REQ-022 The block SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-023 On each push, the block SHALL update acc to acc + in_y, with in_y zero-extended to 24 bits.
REQ-024 On each push, the block SHALL update count to count + 1, wrapping from 16'hFFFF to 0.
REQ-025 When clr is high, the block SHALL set acc, acc_ovf and count to 0 on the next edge; clr takes priority over a same-cycle push for these three outputs, while the FIFO still stores that pushed entry.
REQ-026 The block SHALL not affect FIFO contents or pointers when clr is asserted.

Reset
REQ-027 When rst is asserted, the block SHALL immediately and asynchronously set the level to 0 (EMPTY), both pointers to 0, acc to 0, acc_ovf to 0 and count to 0.
REQ-028 During reset, the block SHALL drive in_ready = 0, out_valid = 0, full = 0 and empty = 1; in_ready rises on the first clock edge after rst deasserts.
REQ-029 Storage contents need not be reset, and out_* are don't-care while out_valid = 0.
REQ-030 On a reset mid-operation, the block SHALL discard all buffered entries with no pop reported.

Configuration
REQ-031 When the macro ARITH_ACC_SAT_EN is defined, the block SHALL clamp acc at 24'hFFFFFF on a push whose sum exceeds 2^24-1, and set acc_ovf.
REQ-032 When ARITH_ACC_SAT_EN is undefined, the block SHALL wrap acc modulo 2^24 and set acc_ovf on carry-out.
REQ-033 In both configurations, acc_ovf SHALL stay set until rst or clr.

Verification
REQ-034 The bench SHALL cover: after reset, push 3 entries with in_y = 100, 200, 300 and out_ready = 0 -> level 3, acc = 600, count = 3, out_y = 100.
REQ-035 The bench SHALL cover: push DEPTH = 4 entries with out_ready = 0 -> full = 1 and in_ready = 0; a 5th in_valid is not stored, and count stays 4.
REQ-036 The bench SHALL cover: with the FIFO at level 2, push and pop in the same cycle -> level stays 2, and out_* advance to the second entry.
REQ-037 The bench SHALL cover: with acc = 24'hFFFF00, push in_y = 18'h3FFFF -> with ARITH_ACC_SAT_EN, acc = 24'hFFFFFF and acc_ovf = 1; without it, acc = 24'h03FEFF and acc_ovf = 1.
REQ-038 The bench SHALL cover: clr high in the same cycle as a push with in_y = 50 -> acc = 0, count = 0, and the entry still pops with out_y = 50.
REQ-039 The bench SHALL cover: assert rst mid-stream at level 3 -> empty = 1 and out_valid = 0 immediately, and acc = 0 and count = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/arith_result_buffer.sv
// arith_result_buffer: first-word-fall-through FIFO for arithmetic results
// (w, x, y, z). It also keeps a running sum of accepted y values (acc), a
// sticky overflow flag and a count of accepted results.
// Optional build macro ARITH_ACC_SAT_EN: when defined, acc clamps at all-ones
// on overflow. When undefined, acc wraps modulo 2^24.
// Either way, acc_ovf is set on overflow and stays set until rst or clr.
module arith_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_w,
  input  logic [10:0] in_x,
  input  logic [17:0] in_y,
  input  logic [10:0] in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_w,
  output logic [10:0] out_x,
  output logic [17:0] out_y,
  output logic [10:0] out_z,
  output logic [23:0] acc,
  output logic        acc_ovf,
  output logic [15:0] count,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  typedef struct packed {
    logic [10:0] w;
    logic [10:0] x;
    logic [17:0] y;
    logic [10:0] z;
  } entry_t;

  state_t        state, state_nxt;
  logic [LW-1:0] level, level_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          live;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic          push, pop;
  logic [24:0]   sum;
  logic [23:0]   acc_nxt;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Level/state register; live holds in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
      level <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      live  <= 1'b1;
    end
  end

  // Next level and state; a simultaneous push and pop leaves the level unchanged
  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 1'b1;
    else if (pop && !push) level_nxt = level - 1'b1;
    state_nxt = S_PARTIAL;
    if (level_nxt == '0)           state_nxt = S_EMPTY;
    else if (level_nxt == FULL_LVL) state_nxt = S_FULL;
  end

  // Handshake and status flags, decoded from registers only
  always_comb begin
    full      = (state == S_FULL);
    empty     = (state == S_EMPTY);
    in_ready  = live && !full;
    out_valid = !empty;
  end

  // Read and write pointers; both wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; its contents are not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{w: in_w, x: in_x, y: in_y, z: in_z};
  end

  // The head entry falls through combinationally to the outputs
  assign head  = mem[rd_ptr];
  assign out_w = head.w;
  assign out_x = head.x;
  assign out_y = head.y;
  assign out_z = head.z;

  // Sum with carry out; the carry selects between clamping and wrapping
  always_comb begin
    sum = {1'b0, acc} + {7'b0, in_y};
`ifdef ARITH_ACC_SAT_EN
    acc_nxt = sum[24] ? 24'hFFFFFF : sum[23:0];
`else
    acc_nxt = sum[23:0];
`endif
  end

  // Accumulator, sticky overflow and result count; clr wins over a same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      count   <= '0;
    end else if (clr) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      count   <= '0;
    end else if (push) begin
      acc     <= acc_nxt;
      acc_ovf <= acc_ovf | sum[24];
      count   <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_arith_result_buffer.sv
// Directed, table-driven bench for arith_result_buffer (DEPTH = 4).
module tb_arith_result_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_w = '0, in_x = '0, in_z = '0;
  logic [17:0] in_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_w, out_x, out_z;
  logic [17:0] out_y;
  logic [23:0] acc;
  logic        acc_ovf;
  logic [15:0] count;
  logic        full, empty;

  int ncmp = 0;
  int nerr = 0;

  arith_result_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_w(out_w), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .acc(acc), .acc_ovf(acc_ovf), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // The w, x and z fields are derived from y so that every field of the head is checked
  function automatic logic [10:0] fw(input logic [17:0] y); return y[10:0] ^ 11'h2A5; endfunction
  function automatic logic [10:0] fx(input logic [17:0] y); return y[10:0] + 11'd3;  endfunction
  function automatic logic [10:0] fz(input logic [17:0] y); return ~y[10:0];         endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, clock it and settle just after the edge
  task automatic step(input logic v, input logic [17:0] y, input logic ordy, input logic c);
    in_valid  = v;
    in_y      = y;
    in_w      = fw(y);
    in_x      = fx(y);
    in_z      = fz(y);
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        vld;
    logic [17:0] y;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic        e_full;
    logic [17:0] e_y;
    logic [23:0] e_acc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic v, input logic [17:0] y, input logic o, input logic c,
                              input logic eov, input logic ef, input logic [17:0] ey,
                              input logic [23:0] ea, input logic [15:0] ec);
    vec_t r;
    r.vld = v; r.y = y; r.ordy = o; r.clr = c;
    r.e_ov = eov; r.e_full = ef; r.e_y = ey; r.e_acc = ea; r.e_cnt = ec;
    return r;
  endfunction

  initial begin
    logic [23:0] e_sat, e_sat2;
    //           vld y    ordy clr  ov full  head  acc   cnt
    vt[0]  = mk(1, 100, 0, 0,  1, 0, 100,  100,  1);
    vt[1]  = mk(1, 200, 0, 0,  1, 0, 100,  300,  2);
    vt[2]  = mk(1, 300, 0, 0,  1, 0, 100,  600,  3);
    vt[3]  = mk(1, 400, 0, 0,  1, 1, 100,  1000, 4);
    vt[4]  = mk(1, 500, 0, 0,  1, 1, 100,  1000, 4);   // refused while full
    vt[5]  = mk(0, 0,   1, 0,  1, 0, 200,  1000, 4);
    vt[6]  = mk(0, 0,   1, 0,  1, 0, 300,  1000, 4);   // level 2
    vt[7]  = mk(1, 600, 1, 0,  1, 0, 400,  1600, 5);   // push+pop, level stays 2
    vt[8]  = mk(0, 0,   1, 0,  1, 0, 600,  1600, 5);   // 500 was never stored
    vt[9]  = mk(0, 0,   1, 0,  0, 0, 0,    1600, 5);
    vt[10] = mk(1, 50,  0, 1,  1, 0, 50,   0,    0);   // clr beats push, entry kept
    vt[11] = mk(0, 0,   1, 0,  0, 0, 0,    0,    0);
    vt[12] = mk(0, 0,   1, 0,  0, 0, 0,    0,    0);   // pop attempt while empty

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_acc", acc, 0);
    chk("rst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", in_ready, 1);

    // Table-driven main sequence
    for (int i = 0; i < 13; i++) begin
      step(vt[i].vld, vt[i].y, vt[i].ordy, vt[i].clr);
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("v%0d_empty", i), empty, !vt[i].e_ov);
      chk($sformatf("v%0d_full", i), full, vt[i].e_full);
      chk($sformatf("v%0d_in_ready", i), in_ready, !vt[i].e_full);
      chk($sformatf("v%0d_acc", i), acc, vt[i].e_acc);
      chk($sformatf("v%0d_count", i), count, vt[i].e_cnt);
      if (vt[i].e_ov) begin
        chk($sformatf("v%0d_out_y", i), out_y, vt[i].e_y);
        chk($sformatf("v%0d_out_w", i), out_w, fw(vt[i].e_y));
        chk($sformatf("v%0d_out_x", i), out_x, fx(vt[i].e_y));
        chk($sformatf("v%0d_out_z", i), out_z, fz(vt[i].e_y));
      end
    end

    // Overflow: 63 x 3FFFF + 3FF3F = FFFF00, then push 3FFFF
    step(0, 0, 1, 1);
    for (int i = 0; i < 63; i++) step(1, 18'h3FFFF, 1, 0);
    step(1, 18'h3FF3F, 1, 0);
    chk("pre_ovf_acc", acc, 24'hFFFF00);
    chk("pre_ovf_flag", acc_ovf, 0);
    chk("pre_ovf_count", count, 64);
`ifdef ARITH_ACC_SAT_EN
    e_sat  = 24'hFFFFFF;
    e_sat2 = 24'hFFFFFF;
`else
    e_sat  = 24'h03FEFF;
    e_sat2 = 24'h03FF00;
`endif
    step(1, 18'h3FFFF, 1, 0);
    chk("ovf_acc", acc, e_sat);
    chk("ovf_flag", acc_ovf, 1);
    step(1, 18'h00001, 1, 0);
    chk("ovf_sticky_acc", acc, e_sat2);
    chk("ovf_sticky_flag", acc_ovf, 1);
    step(0, 0, 1, 1);
    chk("clr_ovf_flag", acc_ovf, 0);
    chk("clr_acc", acc, 0);
    chk("clr_count", count, 0);
    repeat (3) step(0, 0, 1, 0);
    chk("drained_empty", empty, 1);

    // Reset mid-stream at level 3
    step(1, 11, 0, 0);
    step(1, 22, 0, 0);
    step(1, 33, 0, 0);
    chk("mid_pre_out_valid", out_valid, 1);
    chk("mid_pre_count", count, 3);
    chk("mid_pre_acc", acc, 66);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_empty", empty, 1);
    step(1, 77, 0, 0);
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_out_y", out_y, 77);
    chk("post_rst_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
